// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel filter datapath and its frame capture
// back end: default geometry, capture FSM states and error codes.
package sobel_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int IMG_WIDTH_DEF  = 256;
  localparam int IMG_HEIGHT_DEF = 256;
  localparam int OUT_WIDTH_DEF  = IMG_WIDTH_DEF - 2;
  localparam int OUT_HEIGHT_DEF = IMG_HEIGHT_DEF - 2;
  localparam int ADDR_W_DEF     = 16;
  localparam int CSUM_W         = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE,
    ST_ERROR
  } cap_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SHORT    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row counter with a running linear address
// (row*COLS+col), end-of-line and end-of-frame flags for the current position.
module raster_counter #(
  parameter int COLS   = 254,
  parameter int ROWS   = 254,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] addr,
  output logic              line_end,
  output logic              frame_end
);

  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign line_end  = (col_q == ADDR_W'(COLS - 1));
  assign frame_end = line_end && (row_q == ADDR_W'(ROWS - 1));

  always_comb begin
    // NOTE: every _d gets a hold value first so no path through this block infers a latch.
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (step) begin
      if (frame_end) begin
        col_d  = '0;
        row_d  = '0;
        addr_d = '0;
      end else if (line_end) begin
        col_d  = '0;
        row_d  = row_q + ADDR_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        col_d  = col_q + ADDR_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;

endmodule

// File: rtl/sobel_frame_capture.sv
// Captures the Sobel filter's raster output stream into a single-port frame
// RAM, checking frame length and keeping a 24-bit running checksum.
module sobel_frame_capture
  import sobel_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int OUT_HEIGHT = OUT_HEIGHT_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [WIDTH-1:0]  pixel_in,
  input  logic              valid_in,
  input  logic              done_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   pix_count,
  output logic [CSUM_W-1:0] checksum
);

  logic              cnt_clear, cnt_step;
  logic [ADDR_W-1:0] cnt_col, cnt_row, cnt_addr;
  logic              cnt_line_end, cnt_frame_end;

  raster_counter #(
    .COLS  (OUT_WIDTH),
    .ROWS  (OUT_HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_raster_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .step     (cnt_step),
    .col      (cnt_col),
    .row      (cnt_row),
    .addr     (cnt_addr),
    .line_end (cnt_line_end),
    .frame_end(cnt_frame_end)
  );

  // Position outputs serve the pixel feeder; capture only needs the address.
  logic unused_cnt;
  assign unused_cnt = ^{cnt_col, cnt_row, cnt_line_end};

  cap_state_e        state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ADDR_W:0]   pix_count_q, pix_count_d;
  logic [CSUM_W-1:0] checksum_q, checksum_d;

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    err_code_d   = err_code_q;
    pix_count_d  = pix_count_q;
    checksum_d   = checksum_q;
    cnt_clear    = 1'b0;
    cnt_step     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (arm) begin
          state_d     = ST_ARMED;
          cnt_clear   = 1'b1;
          pix_count_d = '0;
          checksum_d  = '0;
          frame_err_d = 1'b0;
          err_code_d  = ERR_NONE;
        end else if (state_q == ST_DONE && valid_in) begin
          state_d     = ST_ERROR;
          frame_err_d = 1'b1;
          if (err_code_q == ERR_NONE) err_code_d = ERR_OVERFLOW;
        end
      end
      ST_ARMED, ST_CAPTURE: begin
        if (valid_in) begin
          cnt_step    = 1'b1;
          wr_en_d     = 1'b1;
          wr_addr_d   = cnt_addr;
          wr_data_d   = pixel_in;
          pix_count_d = pix_count_q + (ADDR_W + 1)'(1);
          checksum_d  = checksum_q + CSUM_W'(pixel_in);
          state_d     = ST_CAPTURE;
          // The pixel counts first; a done on the final pixel is a clean end.
          if (cnt_frame_end) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else if (done_in) begin
            state_d     = ST_ERROR;
            frame_err_d = 1'b1;
            if (err_code_q == ERR_NONE) err_code_d = ERR_SHORT;
          end
        end else if (state_q == ST_CAPTURE && done_in) begin
          state_d     = ST_ERROR;
          frame_err_d = 1'b1;
          if (err_code_q == ERR_NONE) err_code_d = ERR_SHORT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples the pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      pix_count_q  <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      pix_count_q  <= pix_count_d;
      checksum_q   <= checksum_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign pix_count  = pix_count_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_sobel_frame_capture.sv
// Scoreboard bench: a 4x3 capture instance for the directed frame scenarios
// and a full 254x254 instance for the all-255 checksum/address boundary.
module tb_sobel_frame_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, valid_in, done_in;
  logic [7:0]  pixel_in;
  logic        wr_en, busy, frame_done, frame_err;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  err_code;
  logic [16:0] pix_count;
  logic [23:0] checksum;

  logic        arm_b, valid_b;
  logic        wr_en_b, busy_b, frame_done_b, frame_err_b;
  logic [15:0] wr_addr_b;
  logic [7:0]  wr_data_b;
  logic [1:0]  err_code_b;
  logic [16:0] pix_count_b;
  logic [23:0] checksum_b;

  always #5 clk = ~clk;

  sobel_frame_capture #(
    .WIDTH(8), .OUT_WIDTH(4), .OUT_HEIGHT(3), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .pixel_in(pixel_in), .valid_in(valid_in),
    .done_in(done_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .pix_count(pix_count), .checksum(checksum)
  );

  sobel_frame_capture #(
    .WIDTH(8), .OUT_WIDTH(254), .OUT_HEIGHT(254), .ADDR_W(16)
  ) dut_big (
    .clk(clk), .rst(rst), .arm(arm_b), .pixel_in(pixel_in), .valid_in(valid_b),
    .done_in(done_in), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .frame_done(frame_done_b), .frame_err(frame_err_b),
    .err_code(err_code_b), .pix_count(pix_count_b), .checksum(checksum_b)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        fd;
    logic [16:0] cnt;
    logic [23:0] sum;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [16:0] m_cnt;
  logic [23:0] m_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_cnt = '0;
    m_sum = '0;
  endtask

  task automatic push_px(input logic [7:0] p, input logic fd);
    exp_t e;
    e.addr = m_cnt[15:0];
    m_cnt  = m_cnt + 17'd1;
    m_sum  = m_sum + 24'(p);
    e.data = p;
    e.fd   = fd;
    e.cnt  = m_cnt;
    e.sum  = m_sum;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; returns 1 time unit after the edge so the caller
  // can observe the registered response to exactly this cycle.
  task automatic drive(input logic a, input logic v, input logic d, input logic [7:0] p);
    arm      = a;
    valid_in = v;
    done_in  = d;
    pixel_in = p;
    @(posedge clk);
    #1;
    arm      = 1'b0;
    valid_in = 1'b0;
    done_in  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {2'b00, wr_en, busy, frame_done, frame_err, err_code, wr_data, wr_addr}, 32'd0);
    check({tag, "_pix_count"}, 32'(pix_count), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  // Monitor: every write the small DUT presents is matched against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
          check("frame_done_at_wr", 32'(frame_done), 32'(e.fd));
          check("pix_count_at_wr", 32'(pix_count), 32'(e.cnt));
          check("checksum_at_wr", 32'(checksum), 32'(e.sum));
        end
      end else if (frame_done) begin
        check("frame_done_without_wr", 32'(wr_en), 32'd1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; valid_in = 1'b0; done_in = 1'b0; pixel_in = '0;
    arm_b = 1'b0; valid_b = 1'b0;

    // Reset state
    repeat (3) drive(1'b0, 1'b0, 1'b0, 8'd0);
    check_all_zero("reset");
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'd0);

    // Full 4x3 frame, back-to-back pixels 1..12
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    check("t1_busy_armed", 32'(busy), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      push_px(8'(i), i == 12);
      drive(1'b0, 1'b1, 1'b0, 8'(i));
    end
    check("t1_frame_done", 32'(frame_done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    check("t1_frame_done_pulse", 32'(frame_done), 32'd0);
    check("t1_checksum", 32'(checksum), 32'd78);
    check("t1_pix_count", 32'(pix_count), 32'd12);
    check("t1_frame_err", 32'(frame_err), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Same frame with valid 1 on / 2 off
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 12; i++) begin
      push_px(8'(i), i == 12);
      drive(1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 12) check("t2_frame_done", 32'(frame_done), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 8'hAA);
      drive(1'b0, 1'b0, 1'b0, 8'h55);
    end
    check("t2_checksum", 32'(checksum), 32'd78);
    check("t2_pix_count", 32'(pix_count), 32'd12);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Short frame: done after 7 pixels
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 7; i++) begin
      push_px(8'(i), 1'b0);
      drive(1'b0, 1'b1, 1'b0, 8'(i));
    end
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    check("t3_frame_err", 32'(frame_err), 32'd1);
    check("t3_err_code", 32'(err_code), 32'd1);
    check("t3_pix_count", 32'(pix_count), 32'd7);
    check("t3_checksum", 32'(checksum), 32'd28);
    check("t3_busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    check("t3_rearm_err", 32'({frame_err, err_code}), 32'd0);
    check("t3_rearm_pix_count", 32'(pix_count), 32'd0);
    check("t3_rearm_checksum", 32'(checksum), 32'd0);
    check("t3_rearm_busy", 32'(busy), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 8'd0);
    check("t3_stale_done_busy", 32'(busy), 32'd1);
    check("t3_stale_done_err", 32'(frame_err), 32'd0);

    // Overflow: 13 pixels into a 12-pixel frame (already armed)
    model_reset();
    for (int i = 1; i <= 13; i++) begin
      if (i <= 12) push_px(8'(i), i == 12);
      drive(1'b0, 1'b1, 1'b0, 8'(i));
    end
    check("t4_no_write_13", 32'(wr_en), 32'd0);
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check("t4_err_code", 32'(err_code), 32'd2);
    check("t4_pix_count", 32'(pix_count), 32'd12);
    check("t4_checksum", 32'(checksum), 32'd78);
    drive(1'b0, 1'b1, 1'b1, 8'd99);
    check("t4_err_sticky", 32'(err_code), 32'd2);
    check("t4_pix_count_hold", 32'(pix_count), 32'd12);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame, then a fresh frame with done on the final pixel
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      push_px(8'(i), 1'b0);
      drive(1'b0, 1'b1, 1'b0, 8'(i));
    end
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'd50);
    check_all_zero("t5_rst1");
    drive(1'b1, 1'b1, 1'b0, 8'd51);
    check_all_zero("t5_rst2");
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 10; i <= 21; i++) begin
      push_px(8'(i), i == 21);
      drive(1'b0, 1'b1, i == 21, 8'(i));
    end
    check("t5_frame_done", 32'(frame_done), 32'd1);
    check("t5_no_err", 32'({frame_err, err_code}), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    check("t5_checksum", 32'(checksum), 32'd186);
    check("t5_pix_count", 32'(pix_count), 32'd12);
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Full-size frame of 255s: checksum and last address boundary
    arm_b = 1'b1;
    @(posedge clk);
    #1;
    arm_b    = 1'b0;
    valid_b  = 1'b1;
    pixel_in = 8'd255;
    repeat (64516) @(posedge clk);
    #1;
    valid_b = 1'b0;
    check("big_wr_en", 32'(wr_en_b), 32'd1);
    check("big_last_addr", 32'(wr_addr_b), 32'd64515);
    check("big_last_data", 32'(wr_data_b), 32'd255);
    check("big_frame_done", 32'(frame_done_b), 32'd1);
    check("big_checksum", 32'(checksum_b), 32'd16451580);
    check("big_pix_count", 32'(pix_count_b), 32'd64516);
    check("big_err", 32'({frame_err_b, err_code_b}), 32'd0);
    @(posedge clk);
    #1;
    check("big_frame_done_pulse", 32'(frame_done_b), 32'd0);
    check("big_busy", 32'(busy_b), 32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sobel_frame_capture.md
# sobel_frame_capture

Receive-side counterpart of the pixel feeder. Captures the Sobel filter's raster-ordered output stream (`pixel_out`/`valid_out`/`done`) into an external single-port frame RAM. It counts columns and rows, checks the frame length against the expected `(IMG_WIDTH-2) x (IMG_HEIGHT-2)` size, and accumulates a running checksum. It sits directly downstream of `sobel_filter` and replaces the bench-side output collection in hardware builds.

## Interface
- `WIDTH`, 8, pixel bit width
- `OUT_WIDTH`, 254, output frame columns (filter `IMG_WIDTH-2`)
- `OUT_HEIGHT`, 254, output frame rows (filter `IMG_HEIGHT-2`)
- `ADDR_W`, 16, RAM address width; must satisfy `2^ADDR_W >= OUT_WIDTH*OUT_HEIGHT`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `arm`  in  1  one-cycle pulse; begins a new capture
- `pixel_in`  in  WIDTH  filter `pixel_out`
- `valid_in`  in  1  filter `valid_out`; qualifies `pixel_in`
- `done_in`  in  1  filter `done`; end-of-frame indication (level or pulse)
- `wr_en`  out  1  RAM write strobe
- `wr_addr`  out  ADDR_W  RAM write address, `row*OUT_WIDTH+col`
- `wr_data`  out  WIDTH  RAM write data
- `busy`  out  1  high in ARMED or CAPTURE
- `frame_done`  out  1  one-cycle pulse at good frame completion
- `frame_err`  out  1  sticky error flag until next `arm` or `rst`
- `err_code`  out  2  0 none, 1 short frame, 2 overflow
- `pix_count`  out  ADDR_W+1  pixels accepted this frame
- `checksum`  out  24  sum of accepted pixels, mod 2^24

## Operation
- States: IDLE, ARMED, CAPTURE, DONE, ERROR.
- IDLE/DONE/ERROR + `arm`: go to ARMED. On entry, clear col, row, `pix_count`, `checksum`, `frame_err` and `err_code`. Outside these states, `arm` is ignored.
- ARMED + `valid_in`: accept the pixel and go to CAPTURE. ARMED + `done_in` alone is ignored (stale done from the previous frame).
- CAPTURE, accept rule: each `valid_in` cycle writes `pixel_in` at the current address. It then increments col. At `OUT_WIDTH-1`, col wraps to 0 and row increments. `pix_count` increments and `checksum += pixel_in`, truncated to 24 bits.
- Accepting pixel number `OUT_WIDTH*OUT_HEIGHT` takes the FSM to DONE and pulses `frame_done`.
- CAPTURE + `done_in` with `pix_count` below the total (counting a pixel accepted the same cycle): go to ERROR, `err_code=1`.
- DONE + `valid_in` before the next `arm`: no write, `frame_err=1`, `err_code=2`, state becomes ERROR. `done_in` in DONE is ignored.
- `valid_in` and `done_in` in the same cycle: the pixel is accepted first, then the length check is made.
- Error priority: the first error latched wins, and `err_code` is not overwritten.
- `rst` mid-frame: the frame is abandoned, state goes to IDLE, and no further writes occur.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `frame_done=0`, `frame_err=0`, `err_code=0`, `pix_count=0`, `checksum=0`. State is IDLE.
- Latency: `wr_en`, `wr_addr` and `wr_data` are registered and appear 1 cycle after the `valid_in` edge. At most one write per cycle, at full throughput with `valid_in` high every cycle.
- `frame_done` is high the cycle after the last accepted pixel, coincident with the last `wr_en`.
- `pix_count` and `checksum` update in the same cycle as the corresponding `wr_en`.
- `frame_err` and `err_code` assert 1 cycle after the offending input.
- `busy` deasserts in the same cycle that `frame_done` or `frame_err` asserts.
- There is no backpressure. The filter output cannot be stalled, and the RAM must accept a write every cycle.

## Structure
- Shared `sobel_pkg` holds:
  - `WIDTH` default and default image dimensions (256x256, output 254x254)
  - the capture state enum
  - `err_code` localparams `ERR_NONE`, `ERR_SHORT`, `ERR_OVERFLOW`
- One sub-module, `raster_counter`, provides the col/row/linear-address counter with wrap and terminal-count outputs. It is reusable by the pixel feeder. The FSM, checksum and error logic stay in the top module.

## Test plan
- 4x3 frame, `arm`, 12 consecutive valid pixels 1..12 -> writes at addresses 0..11 with matching data, `frame_done` pulse 1 cycle after pixel 12, `checksum=78`, `pix_count=12`.
- Same frame with `valid_in` gaps (1 cycle on, 2 off) -> identical addresses and data, no extra `wr_en`, `frame_done` after the 12th accepted pixel.
- `done_in` after 7 pixels -> `frame_err=1`, `err_code=1`, `pix_count=7`, no `frame_done`; a subsequent `arm` clears the flags.
- 13 pixels into the 4x3 frame -> 12 writes, `frame_done`, then `err_code=2` and no write for pixel 13.
- `rst` asserted after 5 pixels, then `arm` and 12 pixels -> all outputs zero during reset, next frame starts at address 0, `checksum` covers only the new frame.
- All pixels 255 on a 254x254 frame -> `checksum = 64516*255 mod 2^24 = 16451580`, last `wr_addr=64515`.
